// File: rtl/dma_copy_pkg.sv
// dma_copy_pkg: shared state encoding, DMA write-enable codes and protected-window defaults.
package dma_copy_pkg;

    typedef enum logic [2:0] {IDLE, CHECK, RD_REQ, RD_DATA, WR_REQ, DONE, ERR} state_t;

    localparam logic [1:0] DMA_WE_READ = 2'b00;
    localparam logic [1:0] DMA_WE_WORD = 2'b11;

    // Shared with the DMA access monitor so both see the same windows
    localparam logic [15:0] SDATA_BASE_DEF = 16'h0400;
    localparam logic [15:0] SDATA_SIZE_DEF = 16'h0C00;
    localparam logic [15:0] CTR_BASE_DEF   = 16'h0270;
    localparam logic [15:0] CTR_SIZE_DEF   = 16'h0020;

    function automatic logic in_window(input logic [15:0] a, input logic [15:0] base, input logic [15:0] size);
        return ({1'b0, a} >= {1'b0, base}) && ({1'b0, a} < ({1'b0, base} + {1'b0, size}));
    endfunction

endpackage

// File: rtl/dma_region_check.sv
// dma_region_check: flags an address that falls in the secure-data or counter window.
module dma_region_check import dma_copy_pkg::*; #(
    parameter logic [15:0] SDATA_BASE = SDATA_BASE_DEF,
    parameter logic [15:0] SDATA_SIZE = SDATA_SIZE_DEF,
    parameter logic [15:0] CTR_BASE   = CTR_BASE_DEF,
    parameter logic [15:0] CTR_SIZE   = CTR_SIZE_DEF
) (
    input  logic [15:0] addr,
    output logic        in_protected
);

    assign in_protected = in_window(addr, SDATA_BASE, SDATA_SIZE) || in_window(addr, CTR_BASE, CTR_SIZE);

endmodule

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: DMA block copier that refuses to touch protected windows.
// Optional fill mode (write fill_pattern, no reads) is enabled by defining DMA_COPY_FILL_EN.
module dma_copy_engine import dma_copy_pkg::*; #(
    parameter logic [15:0] SDATA_BASE = SDATA_BASE_DEF,
    parameter logic [15:0] SDATA_SIZE = SDATA_SIZE_DEF,
    parameter logic [15:0] CTR_BASE   = CTR_BASE_DEF,
    parameter logic [15:0] CTR_SIZE   = CTR_SIZE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] src_addr,
    input  logic [15:0] dst_addr,
    input  logic [15:0] len,
`ifdef DMA_COPY_FILL_EN
    input  logic        fill,
    input  logic [15:0] fill_pattern,
`endif
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] dma_addr,
    output logic        dma_en,
    output logic [1:0]  dma_we,
    output logic [15:0] dma_din,
    input  logic [15:0] dma_dout,
    input  logic        dma_ready,
    input  logic        dma_resp
);

    state_t      state;
    logic [15:0] src, dst, rem;
    logic        wrap, src_prot, dst_prot, src_bad;
    logic [16:0] src_nx, dst_nx;

    assign src_nx = {1'b0, src} + 17'd2;
    assign dst_nx = {1'b0, dst} + 17'd2;

    dma_region_check #(.SDATA_BASE(SDATA_BASE), .SDATA_SIZE(SDATA_SIZE), .CTR_BASE(CTR_BASE), .CTR_SIZE(CTR_SIZE))
        u_src_chk (.addr(src), .in_protected(src_prot));
    dma_region_check #(.SDATA_BASE(SDATA_BASE), .SDATA_SIZE(SDATA_SIZE), .CTR_BASE(CTR_BASE), .CTR_SIZE(CTR_SIZE))
        u_dst_chk (.addr(dst), .in_protected(dst_prot));

`ifdef DMA_COPY_FILL_EN
    logic fill_mode;
    assign src_bad = src_prot && !fill_mode;
`else
    assign src_bad = src_prot;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            dma_en   <= 1'b0;
            dma_we   <= DMA_WE_READ;
            dma_addr <= 16'd0;
            dma_din  <= 16'd0;
            src      <= 16'd0;
            dst      <= 16'd0;
            rem      <= 16'd0;
            wrap     <= 1'b0;
`ifdef DMA_COPY_FILL_EN
            fill_mode <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    src   <= src_addr & 16'hFFFE;
                    dst   <= dst_addr & 16'hFFFE;
                    rem   <= len;
                    err   <= 1'b0;
                    wrap  <= 1'b0;
                    busy  <= 1'b1;
                    state <= CHECK;
`ifdef DMA_COPY_FILL_EN
                    fill_mode <= fill;
                    if (fill) dma_din <= fill_pattern;
`endif
                end
                CHECK: if (rem == 16'd0) begin
                    done  <= 1'b1;
                    state <= DONE;
                end else if (wrap || src_bad || dst_prot) begin
                    err   <= 1'b1;
                    state <= ERR;
                end
`ifdef DMA_COPY_FILL_EN
                else if (fill_mode) begin
                    dma_en   <= 1'b1;
                    dma_we   <= DMA_WE_WORD;
                    dma_addr <= dst;
                    state    <= WR_REQ;
                end
`endif
                else begin
                    dma_en   <= 1'b1;
                    dma_we   <= DMA_WE_READ;
                    dma_addr <= src;
                    state    <= RD_REQ;
                end
                RD_REQ: if (dma_ready) begin
                    dma_en <= 1'b0;
                    state  <= RD_DATA;
                end
                RD_DATA: if (dma_resp) begin
                    err   <= 1'b1;
                    state <= ERR;
                end else begin
                    dma_din  <= dma_dout;
                    dma_en   <= 1'b1;
                    dma_we   <= DMA_WE_WORD;
                    dma_addr <= dst;
                    state    <= WR_REQ;
                end
                // A carry out of either pointer only matters if another word remains
                WR_REQ: if (dma_ready) begin
                    dma_en <= 1'b0;
                    dma_we <= DMA_WE_READ;
                    src    <= src_nx[15:0];
                    dst    <= dst_nx[15:0];
                    wrap   <= src_nx[16] || dst_nx[16];
                    rem    <= rem - 16'd1;
                    state  <= CHECK;
                end
                DONE, ERR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
